// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped data cache
// Holds the controller state encoding, the line count, the block width and the
// tag/index/offset field widths of the 8-bit byte address.
package dcache_pkg;

    localparam int NUM_LINES = 8;
    localparam int BLOCK_W   = 32;
    localparam int TAG_W     = 3;
    localparam int INDEX_W   = 3;
    localparam int OFFSET_W  = 2;
    localparam int MADDR_W   = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

endpackage

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - miss-handling FSM and main-memory strobes for dcache
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   read, write         CPU request
//   hit                 combinational hit for the current address
//   line_dirty          selected line is valid and dirty (eviction needed)
//   addr_tag, index     tag/index of the current CPU address
//   stored_tag          tag held in the selected line
//   mem_busywait        main-memory stall
//   busywait            CPU stall
//   idle                controller in IDLE (CPU-side updates allowed)
//   refill              load the returned block into the selected line
//   mem_read, mem_write, mem_address   main-memory block request
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               read,
    input  logic               write,
    input  logic               hit,
    input  logic               line_dirty,
    input  logic [TAG_W-1:0]   addr_tag,
    input  logic [TAG_W-1:0]   stored_tag,
    input  logic [INDEX_W-1:0] index,
    input  logic               mem_busywait,
    output logic               busywait,
    output logic               idle,
    output logic               refill,
    output logic               mem_read,
    output logic               mem_write,
    output logic [MADDR_W-1:0] mem_address
);

    state_t state;
    state_t next_state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if ((read || write) && !hit) begin
                    next_state = line_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        idle        = 1'b0;
        busywait    = 1'b1;
        refill      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        case (state)
            IDLE: begin
                idle     = 1'b1;
                busywait = (read || write) && !hit;
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {stored_tag, index};
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = {addr_tag, index};
                // A reset in the completing cycle must not revalidate the line.
                refill      = !mem_busywait && !RESET;
            end
            default: begin
                busywait = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - 8-line direct-mapped write-back data cache, 4-byte blocks
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   READ, WRITE, ADDRESS       CPU request (held until BUSYWAIT low)
//   WRITEDATA, READDATA        CPU store/load byte
//   BUSYWAIT                   CPU stall
//   MEM_READ, MEM_WRITE        main-memory block strobes
//   MEM_ADDRESS                block address {tag,index}
//   MEM_WRITEDATA              evicted block, byte0 in [7:0]
//   MEM_READDATA, MEM_BUSYWAIT returned block and memory stall
module dcache
    import dcache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [7:0]         ADDRESS,
    input  logic [7:0]         WRITEDATA,
    output logic [7:0]         READDATA,
    output logic               BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [MADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    logic [BLOCK_W-1:0]   data_array [NUM_LINES];
    logic [TAG_W-1:0]     tag_array  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [BLOCK_W-1:0]  block;
    logic [TAG_W-1:0]    stored_tag;
    logic                hit;
    logic                idle;
    logic                refill;
    logic                cpu_write;

    assign addr_tag   = ADDRESS[7:5];
    assign index      = ADDRESS[4:2];
    assign offset     = ADDRESS[1:0];
    assign block      = data_array[index];
    assign stored_tag = tag_array[index];
    assign hit        = valid[index] && (stored_tag == addr_tag);

    // WRITE wins over READ, so a simultaneous request is a store.
    assign cpu_write  = idle && WRITE && hit;

    assign READDATA      = (READ && hit) ? block[{offset, 3'b000} +: 8] : 8'h00;
    assign MEM_WRITEDATA = MEM_WRITE ? block : '0;

    dcache_ctrl u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .read         (READ),
        .write        (WRITE),
        .hit          (hit),
        .line_dirty   (valid[index] && dirty[index]),
        .addr_tag     (addr_tag),
        .stored_tag   (stored_tag),
        .index        (index),
        .mem_busywait (MEM_BUSYWAIT),
        .busywait     (BUSYWAIT),
        .idle         (idle),
        .refill       (refill),
        .mem_read     (MEM_READ),
        .mem_write    (MEM_WRITE),
        .mem_address  (MEM_ADDRESS)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (refill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (cpu_write) begin
            dirty[index] <= 1'b1;
        end
    end

    // Data and tags carry no reset; valid alone qualifies them.
    always_ff @(posedge CLK) begin
        if (refill) begin
            data_array[index] <= MEM_READDATA;
            tag_array[index]  <= addr_tag;
        end else if (cpu_write) begin
            data_array[index][{offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed scoreboard bench for dcache
module tb_dcache;
    import dcache_pkg::*;

    localparam int LAT = 5;

    typedef struct packed {
        logic       chk;
        logic [7:0] data;
    } rd_exp_t;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int total = 0;
    int bad   = 0;
    int overlap = 0;
    int mem_cnt = 0;

    logic [31:0] mem [64];
    rd_exp_t     rd_q [$];
    txn_t        txn_q [$];

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: each strobed request completes in its LAT-th cycle.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt != LAT - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (MEM_READ && MEM_WRITE) overlap++;
        if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
            txn_t e;
            check("txn_expected", 32'(txn_q.size() != 0), 32'd1);
            if (txn_q.size() != 0) begin
                e = txn_q.pop_front();
                check("txn_kind", 32'(MEM_WRITE), 32'(e.wr));
                check("txn_addr", 32'(MEM_ADDRESS), 32'(e.addr));
                if (e.wr) check("txn_wdata", MEM_WRITEDATA, e.data);
            end
        end
    end

    // Caller sits just after a posedge; returns just after the posedge that
    // commits the resolved request, with the request dropped.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input int exp_stalls, input logic chk, input logic [7:0] exp_data);
        rd_exp_t e;
        int      stalls;
        logic    done;
        rd_q.push_back('{chk: chk, data: exp_data});
        READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge CLK); #1;
            end
        end
        check({tag, "_resolved"}, 32'(done), 32'd1);
        e = rd_q.pop_front();
        if (e.chk) check({tag, "_rdata"}, 32'(READDATA), 32'(e.data));
        check({tag, "_stalls"}, stalls, exp_stalls);
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {8'(i), 8'(i), 8'(i), 8'(i)};
        mem[6'h09] = 32'hDDCCBBAA;
        mem[6'h11] = 32'h87654321;
        mem[6'h02] = 32'h44332211;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
        check("rst_readdata", 32'(READDATA), 32'd0);
        check("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
        check("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
        @(posedge CLK); #1;

        // Cold read: 1 miss cycle + 5 memory cycles.
        txn_q.push_back('{wr: 1'b0, addr: 6'h09, data: 32'h0});
        access("cold_read", 1'b1, 1'b0, 8'h25, 8'h00, 6, 1'b1, 8'hBB);
        check("cold_read_dirty", 32'(dut.dirty[1]), 32'd0);

        // Write hit, then read back.
        access("write_hit", 1'b0, 1'b1, 8'h26, 8'h5F, 0, 1'b0, 8'h00);
        access("read_back", 1'b1, 1'b0, 8'h26, 8'h00, 0, 1'b1, 8'h5F);
        check("write_hit_dirty", 32'(dut.dirty[1]), 32'd1);
        access("read_other_byte", 1'b1, 1'b0, 8'h27, 8'h00, 0, 1'b1, 8'hDD);

        // Dirty eviction: write back line 1 then fetch 0x11.
        txn_q.push_back('{wr: 1'b1, addr: 6'h09, data: 32'hDD5FBBAA});
        txn_q.push_back('{wr: 1'b0, addr: 6'h11, data: 32'h0});
        access("evict_read", 1'b1, 1'b0, 8'h45, 8'h00, 11, 1'b1, 8'h43);
        check("evict_dirty_clear", 32'(dut.dirty[1]), 32'd0);
        check("evict_mem_updated", mem[6'h09], 32'hDD5FBBAA);
        access("write_only_no_rdata", 1'b0, 1'b1, 8'h44, 8'hA5, 0, 1'b1, 8'h00);

        // Simultaneous READ and WRITE is a store.
        access("rw_hit", 1'b1, 1'b1, 8'h45, 8'h77, 0, 1'b0, 8'h00);
        access("rw_follow", 1'b1, 1'b0, 8'h45, 8'h00, 0, 1'b1, 8'h77);

        // Reset in the first FETCH cycle of a clean miss.
        READ = 1'b1; ADDRESS = 8'h08;
        @(negedge CLK);
        check("abort_miss_busy", 32'(BUSYWAIT), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        check("abort_fetch_strobe", 32'(MEM_READ), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b0; READ = 1'b0;
        @(negedge CLK);
        check("abort_mem_read", 32'(MEM_READ), 32'd0);
        check("abort_state", 32'(dut.u_ctrl.state), 32'(IDLE));
        check("abort_busywait", 32'(BUSYWAIT), 32'd0);
        @(posedge CLK); #1;
        txn_q.push_back('{wr: 1'b0, addr: 6'h02, data: 32'h0});
        access("reread_after_abort", 1'b1, 1'b0, 8'h08, 8'h00, 6, 1'b1, 8'h11);
        // Reset also dropped line 1, so its old dirty data is gone without writeback.
        txn_q.push_back('{wr: 1'b0, addr: 6'h11, data: 32'h0});
        access("line1_after_reset", 1'b1, 1'b0, 8'h45, 8'h00, 6, 1'b1, 8'h43);

        repeat (2) @(negedge CLK);
        check("no_strobe_overlap", overlap, 0);
        check("txn_all_seen", txn_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
